// File: rtl/rst_seq_mgr.sv
// -----------------------------------------------------------------------------
// rst_seq_mgr
//
// Purpose:
//   Reset sequencer for a small SoC with NUM_DOMAINS reset domains. Domain 0 is
//   the debug domain. It leaves reset at the first clock edge after power-on
//   reset and is never reset again, except by rst_ni. Domains 1..N-1 are
//   released in a staggered sequence. They can be put back into reset by a
//   programming reset (prog_rst_ni), a non-debug-module reset (ndmreset_i) or
//   per-domain software requests (sw_rst_req_i). A sticky cause register
//   records why the last reset happened.
//
// Ports:
//   clk_i          in   system clock
//   rst_ni         in   asynchronous active-low power-on reset
//   prog_rst_ni    in   asynchronous active-low programming reset (synchronised)
//   ndmreset_i     in   synchronous active-high ndm reset request (level)
//   sw_rst_req_i   in   per-domain software reset request pulses (bit 0 ignored)
//   cause_clr_i    in   clears rst_cause_o (a same-cycle set wins for its bit)
//   domain_rst_no  out  registered active-low per-domain resets
//   rst_cause_o    out  sticky cause: [0] POR, [1] prog, [2] ndm, [3] sw
//   busy_o         out  high whenever the sequencer is not in RUN
// -----------------------------------------------------------------------------
module rst_seq_mgr #(
  parameter int NUM_DOMAINS    = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int BOOT_WAIT_PROG = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   prog_rst_ni,
  input  logic                   ndmreset_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  input  logic                   cause_clr_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_no,
  output logic [3:0]             rst_cause_o,
  output logic                   busy_o
);

  // Stagger counter counts edges since RELEASE entry, up to the edge that
  // releases the last domain.
  localparam int STAG_MAX = (NUM_DOMAINS - 1) * STRETCH_CYCLES;
  localparam int STAG_W   = $clog2(STAG_MAX + 1);
  localparam int SW_W     = $clog2(STRETCH_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PROG    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [STAG_W-1:0]   r_stag_cnt;
  logic [STAG_W-1:0]   w_stag_next;
  logic [STAG_W-1:0]   w_stag_inc;
  logic [3:0]          r_cause;
  logic [3:0]          w_cause_next;
  logic                r_dom0_n;

  logic [SYNC_STAGES-1:0] r_prog_sync;
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic                   w_prog_req;

  logic                w_releasing;
  logic                w_running;
  logic                w_enter_prog;
  logic                w_enter_hold;
  logic                w_sw_accept;

  // Debug domain never takes software resets.
  logic                w_unused_sw0;
  assign w_unused_sw0 = sw_rst_req_i[0];

  // ---------------------------------------------------------------------------
  // prog_rst_ni synchroniser. Its flops clear to 0 on power-on reset. A 0 in
  // the last stage would otherwise read as a programming request. r_sync_vld
  // shifts in ones alongside the data and marks when the data stage holds a
  // real sample of prog_rst_ni. Until then the block reports no request, so
  // power-on does not fake a programming pulse. Once valid, the latency from
  // a prog_rst_ni edge to its use is SYNC_STAGES edges.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prog_sync <= '0;
      r_sync_vld  <= '0;
    end else begin
      r_prog_sync <= {r_prog_sync[SYNC_STAGES-2:0], prog_rst_ni};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_prog_req = r_sync_vld[SYNC_STAGES-1] & ~r_prog_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM state, stagger counter, cause register, debug-domain reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RESET;
      r_stag_cnt <= '0;
      r_cause    <= 4'b0001;
      r_dom0_n   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_stag_cnt <= w_stag_next;
      r_cause    <= w_cause_next;
      // The first edge after rst_ni deasserts releases the debug domain.
      r_dom0_n   <= 1'b1;
    end
  end

  assign w_stag_inc = r_stag_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    // The counter is zero in every state except RELEASE, so entry clears it.
    w_stag_next  = '0;

    case (r_state)
      ST_RESET: begin
        w_state_next = (BOOT_WAIT_PROG != 0) ? ST_IDLE : ST_RELEASE;
      end
      ST_IDLE: begin
        if (w_prog_req) w_state_next = ST_PROG;
      end
      ST_PROG: begin
        if (!w_prog_req) w_state_next = ST_RELEASE;
      end
      ST_HOLD: begin
        if (w_prog_req)       w_state_next = ST_PROG;
        else if (!ndmreset_i) w_state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A new request aborts the stagger. Programming wins over ndm.
        if (w_prog_req)      w_state_next = ST_PROG;
        else if (ndmreset_i) w_state_next = ST_HOLD;
        else begin
          w_stag_next = w_stag_inc;
          if (w_stag_inc == STAG_W'(STAG_MAX)) w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_prog_req)      w_state_next = ST_PROG;
        else if (ndmreset_i) w_state_next = ST_HOLD;
      end
      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  // Staying in or finishing RELEASE drives the stagger pattern. Staying in
  // RUN services software requests. Every other path drives domains 1..N-1
  // low and clears their counters. That covers entry to PROG/HOLD and entry
  // to RELEASE.
  assign w_releasing  = (r_state == ST_RELEASE) &&
                        ((w_state_next == ST_RELEASE) || (w_state_next == ST_RUN));
  assign w_running    = (r_state == ST_RUN) && (w_state_next == ST_RUN);
  assign w_enter_prog = (w_state_next == ST_PROG) && (r_state != ST_PROG);
  assign w_enter_hold = (w_state_next == ST_HOLD) && (r_state != ST_HOLD);
  assign w_sw_accept  = w_running && (|sw_rst_req_i[NUM_DOMAINS-1:1]);

  always_comb begin
    w_cause_next    = cause_clr_i ? 4'b0000 : r_cause;
    w_cause_next[1] = w_cause_next[1] | w_enter_prog;
    w_cause_next[2] = w_cause_next[2] | w_enter_hold;
    w_cause_next[3] = w_cause_next[3] | w_sw_accept;
  end

  // ---------------------------------------------------------------------------
  // Per-domain reset registers and software stretch counters (domains 1..N-1)
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 1; gi < NUM_DOMAINS; gi++) begin : g_dom
      logic [SW_W-1:0] r_sw_cnt;
      logic [SW_W-1:0] w_sw_cnt_next;
      logic            r_dom_n;
      logic            w_dom_next;

      always_comb begin
        w_sw_cnt_next = '0;
        w_dom_next    = 1'b0;
        if (w_releasing) begin
          // Domain gi comes out at the gi*STRETCH_CYCLES-th edge after entry.
          w_dom_next = (w_stag_inc >= STAG_W'(gi * STRETCH_CYCLES));
        end else if (w_running) begin
          if (sw_rst_req_i[gi]) begin
            // Also restarts a stretch that is already running.
            w_sw_cnt_next = SW_W'(STRETCH_CYCLES);
            w_dom_next    = 1'b0;
          end else if (r_sw_cnt != '0) begin
            // The domain stays low until the counter reaches zero. It then
            // rises STRETCH_CYCLES edges after the request edge.
            w_sw_cnt_next = r_sw_cnt - 1'b1;
            w_dom_next    = (r_sw_cnt == SW_W'(1));
          end else begin
            w_dom_next    = 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_sw_cnt <= '0;
          r_dom_n  <= 1'b0;
        end else begin
          r_sw_cnt <= w_sw_cnt_next;
          r_dom_n  <= w_dom_next;
        end
      end

      assign domain_rst_no[gi] = r_dom_n;
    end
  endgenerate

  assign domain_rst_no[0] = r_dom0_n;
  assign rst_cause_o      = r_cause;
  assign busy_o           = (r_state != ST_RUN);

endmodule

// File: tb/tb_rst_seq_mgr.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_mgr
//
// Directed bench for rst_seq_mgr with NUM_DOMAINS=4, STRETCH_CYCLES=8,
// SYNC_STAGES=2 and BOOT_WAIT_PROG=1. Inputs change on the falling edge of
// clk_i. Outputs are sampled on the falling edge, halfway between rising
// edges. Expected edge counts are hand-derived:
//   - The FSM sees prog_rst_ni 2 edges after it changes, and acts on the 3rd.
//   - Domain k rises 8*k edges after RELEASE entry.
//   - RUN is entered together with domain 3.
// -----------------------------------------------------------------------------
module tb_rst_seq_mgr;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       prog_rst_ni;
  logic       ndmreset_i;
  logic [3:0] sw_rst_req_i;
  logic       cause_clr_i;
  logic [3:0] domain_rst_no;
  logic [3:0] rst_cause_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  rst_seq_mgr #(
    .NUM_DOMAINS   (4),
    .STRETCH_CYCLES(8),
    .SYNC_STAGES   (2),
    .BOOT_WAIT_PROG(1)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .prog_rst_ni  (prog_rst_ni),
    .ndmreset_i   (ndmreset_i),
    .sw_rst_req_i (sw_rst_req_i),
    .cause_clr_i  (cause_clr_i),
    .domain_rst_no(domain_rst_no),
    .rst_cause_o  (rst_cause_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Power-on reset, release of the debug domain, then parking in IDLE.
  task automatic test_reset();
    rst_ni = 1'b0; prog_rst_ni = 1'b1; ndmreset_i = 1'b0;
    sw_rst_req_i = 4'b0000; cause_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b0000 || rst_cause_o !== 4'b0001 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL por_hold: dom=%b cause=%b busy=%b, need dom=0000 cause=0001 busy=1",
               domain_rst_no, rst_cause_o, busy_o);
    end
    rst_ni = 1'b1;
    #1;
    n_tests++;
    if (domain_rst_no !== 4'b0000) begin
      n_fail++;
      $display("FAIL por_no_edge: dom=%b, need 0000", domain_rst_no);
    end
    @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b0001 || busy_o !== 1'b1 || rst_cause_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL por_first_edge: dom=%b busy=%b cause=%b, need 0001 1 0001",
               domain_rst_no, busy_o, rst_cause_o);
    end
    repeat (10) @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b0001 || busy_o !== 1'b1 || rst_cause_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL idle_wait: dom=%b busy=%b cause=%b, need 0001 1 0001",
               domain_rst_no, busy_o, rst_cause_o);
    end
    $display("[TB] test_reset done");
  endtask

  // Programming pulse from IDLE: 5 cycles low, then staggered release.
  // A software request during RELEASE must be ignored.
  task automatic test_prog_boot();
    logic [3:0] exp;
    prog_rst_ni = 1'b0;
    repeat (5) @(negedge clk_i);
    prog_rst_ni = 1'b1;
    // Edge b after the rise: b=1,2 still PROG, b=3 enters RELEASE.
    // Domains 1/2/3 rise at b=11/19/27.
    for (int b = 1; b <= 30; b++) begin
      @(negedge clk_i);
      exp = {(b >= 27), (b >= 19), (b >= 11), 1'b1};
      n_tests++;
      if (domain_rst_no !== exp || busy_o !== (b < 27)) begin
        n_fail++;
        $display("FAIL prog_stagger b=%0d: dom=%b busy=%b, need dom=%b busy=%b",
                 b, domain_rst_no, busy_o, exp, (b < 27));
      end
      if (b == 5) sw_rst_req_i = 4'b1110;
      if (b == 6) sw_rst_req_i = 4'b0000;
    end
    n_tests++;
    if (rst_cause_o !== 4'b0011) begin
      n_fail++;
      $display("FAIL prog_cause: cause=%b, need 0011", rst_cause_o);
    end
    $display("[TB] test_prog_boot done");
  endtask

  // ndmreset_i held high for 3 cycles in RUN.
  task automatic test_ndm();
    logic [3:0] exp;
    ndmreset_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b0001 || busy_o !== 1'b1 || rst_cause_o !== 4'b0111) begin
      n_fail++;
      $display("FAIL ndm_enter: dom=%b busy=%b cause=%b, need 0001 1 0111",
               domain_rst_no, busy_o, rst_cause_o);
    end
    repeat (2) @(negedge clk_i);
    ndmreset_i = 1'b0;
    // Edge d=1 enters RELEASE. Domains rise at d=9/17/25.
    for (int d = 1; d <= 28; d++) begin
      @(negedge clk_i);
      exp = {(d >= 25), (d >= 17), (d >= 9), 1'b1};
      n_tests++;
      if (domain_rst_no !== exp || busy_o !== (d < 25)) begin
        n_fail++;
        $display("FAIL ndm_stagger d=%0d: dom=%b busy=%b, need dom=%b busy=%b",
                 d, domain_rst_no, busy_o, exp, (d < 25));
      end
    end
    $display("[TB] test_ndm done");
  endtask

  // Software request 4'b0101 for one cycle. Only domain 2 stretches.
  task automatic test_sw();
    logic [3:0] exp;
    sw_rst_req_i = 4'b0101;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk_i);
      sw_rst_req_i = 4'b0000;
      exp = (e <= 8) ? 4'b1011 : 4'b1111;
      n_tests++;
      if (domain_rst_no !== exp || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_stretch e=%0d: dom=%b busy=%b, need dom=%b busy=0",
                 e, domain_rst_no, busy_o, exp);
      end
    end
    n_tests++;
    if (rst_cause_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL sw_cause: cause=%b, need 1111", rst_cause_o);
    end
    $display("[TB] test_sw done");
  endtask

  // Repeated request on domain 1 at edge 4 restarts the count.
  // The domain then rises at edge 12, not edge 9.
  task automatic test_back_to_back();
    logic [3:0] exp;
    sw_rst_req_i = 4'b0010;
    for (int f = 1; f <= 14; f++) begin
      @(negedge clk_i);
      exp = (f < 12) ? 4'b1101 : 4'b1111;
      n_tests++;
      if (domain_rst_no !== exp) begin
        n_fail++;
        $display("FAIL sw_restart f=%0d: dom=%b, need %b", f, domain_rst_no, exp);
      end
      if (f == 1) sw_rst_req_i = 4'b0000;
      if (f == 3) sw_rst_req_i = 4'b0010;
      if (f == 4) sw_rst_req_i = 4'b0000;
    end
    $display("[TB] test_back_to_back done");
  endtask

  // Clear coinciding with a software request keeps only bit 3. A clear on
  // its own empties the register.
  task automatic test_cause_clr();
    cause_clr_i = 1'b1; sw_rst_req_i = 4'b0010;
    @(negedge clk_i);
    cause_clr_i = 1'b0; sw_rst_req_i = 4'b0000;
    n_tests++;
    if (rst_cause_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL clr_with_sw: cause=%b, need 1000", rst_cause_o);
    end
    repeat (10) @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b1111) begin
      n_fail++;
      $display("FAIL clr_sw_recover: dom=%b, need 1111", domain_rst_no);
    end
    cause_clr_i = 1'b1;
    @(negedge clk_i);
    cause_clr_i = 1'b0;
    n_tests++;
    if (rst_cause_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_alone: cause=%b, need 0000", rst_cause_o);
    end
    $display("[TB] test_cause_clr done");
  endtask

  // prog_rst_ni falling in RUN takes effect exactly 3 edges later.
  task automatic test_prog_in_run();
    prog_rst_ni = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk_i);
      n_tests++;
      if (domain_rst_no !== 4'b1111 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL prog_latency j=%0d: dom=%b busy=%b, need 1111 0", j, domain_rst_no, busy_o);
      end
    end
    @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b0001 || busy_o !== 1'b1 || rst_cause_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL prog_run_enter: dom=%b busy=%b cause=%b, need 0001 1 0010",
               domain_rst_no, busy_o, rst_cause_o);
    end
    prog_rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b1111 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_run_back: dom=%b busy=%b, need 1111 0", domain_rst_no, busy_o);
    end
    $display("[TB] test_prog_in_run done");
  endtask

  // prog and ndm together: HOLD first (prog still in the synchroniser), then
  // PROG wins. Release follows prog, not ndm. rst_ni then drops mid-RELEASE.
  task automatic test_prog_ndm_por();
    logic [3:0] exp;
    cause_clr_i = 1'b1;
    @(negedge clk_i);
    cause_clr_i = 1'b0;
    n_tests++;
    if (rst_cause_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL coinc_preclear: cause=%b, need 0000", rst_cause_o);
    end
    prog_rst_ni = 1'b0; ndmreset_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b0001 || rst_cause_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL coinc_g1: dom=%b cause=%b, need 0001 0100", domain_rst_no, rst_cause_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (rst_cause_o !== 4'b0110) begin
      n_fail++;
      $display("FAIL coinc_prog_taken: cause=%b, need 0110", rst_cause_o);
    end
    prog_rst_ni = 1'b1; ndmreset_i = 1'b0;
    // From PROG, RELEASE starts at h=3, so domain 1 rises at h=11. A stay in
    // HOLD would have released at h=1 and raised domain 1 at h=9.
    for (int h = 1; h <= 14; h++) begin
      @(negedge clk_i);
      exp = (h >= 11) ? 4'b0011 : 4'b0001;
      n_tests++;
      if (domain_rst_no !== exp) begin
        n_fail++;
        $display("FAIL coinc_release h=%0d: dom=%b, need %b", h, domain_rst_no, exp);
      end
    end
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if (domain_rst_no !== 4'b0000 || busy_o !== 1'b1 || rst_cause_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_por: dom=%b busy=%b cause=%b, need 0000 1 0001",
               domain_rst_no, busy_o, rst_cause_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (domain_rst_no !== 4'b0001 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_por_exit: dom=%b busy=%b, need 0001 1", domain_rst_no, busy_o);
    end
    $display("[TB] test_prog_ndm_por done");
  endtask

  initial begin
    test_reset();
    test_prog_boot();
    test_ndm();
    test_sw();
    test_back_to_back();
    test_cause_clr();
    test_prog_in_run();
    test_prog_ndm_por();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_mgr.md
RST_SEQ_MGR -- requirements
Module: rst_seq_mgr

Interface
REQ-001 The block SHALL have parameter NUM_DOMAINS, default 4, number of reset domains (>=2); domain 0 is the debug domain.
REQ-002 The block SHALL have parameter STRETCH_CYCLES, default 8, minimum hold/stagger length in clk_i cycles (>=1).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, depth of the prog_rst_ni synchroniser (>=2).
REQ-004 The block SHALL have parameter BOOT_WAIT_PROG, default 1: 1 means wait for a programming pulse after power-on, 0 means release immediately.
REQ-005 The block SHALL have port clk_i, input, 1 bit, system clock.
REQ-006 The block SHALL have port rst_ni, input, 1 bit, asynchronous active-low power-on reset.
REQ-007 The block SHALL have port prog_rst_ni, input, 1 bit, asynchronous active-low programming reset.
REQ-008 The block SHALL have port ndmreset_i, input, 1 bit, synchronous active-high non-debug-module reset request (level).
REQ-009 The block SHALL have port sw_rst_req_i, input, NUM_DOMAINS bits, per-domain software reset request pulses.
REQ-010 The block SHALL have port cause_clr_i, input, 1 bit, clears rst_cause_o.
REQ-011 The block SHALL have port domain_rst_no, output, NUM_DOMAINS bits, registered active-low per-domain resets.
REQ-012 The block SHALL have port rst_cause_o, output, 4 bits, sticky cause: [0] POR, [1] prog, [2] ndm, [3] sw.
REQ-013 The block SHALL have port busy_o, output, 1 bit, high whenever the FSM is not in RUN.

Function
REQ-014 prog_rst_ni SHALL pass through SYNC_STAGES flops (async-reset low) before use; all other inputs are used directly.
REQ-015 The FSM SHALL have states RESET, IDLE, PROG, HOLD, RELEASE, RUN.
REQ-016 RESET SHALL be left at the first edge after rst_ni deasserts: to IDLE if BOOT_WAIT_PROG=1, else to RELEASE; domain_rst_no[0] SHALL go high at that same edge and SHALL thereafter be driven low only by rst_ni.
REQ-017 IDLE SHALL go to PROG when synchronised prog is low, and stay otherwise.
REQ-018 PROG SHALL hold domains 1..N-1 low and go to RELEASE on the first cycle synchronised prog is high.
REQ-019 RELEASE SHALL clear a stagger counter on entry; domain k (k=1..N-1) SHALL deassert at the k*STRETCH_CYCLES-th edge after entry; RELEASE SHALL go to RUN at the edge that releases domain N-1.
REQ-020 RUN priority SHALL be: synchronised prog low -> PROG; else ndmreset_i high -> HOLD; else software requests are serviced.
REQ-021 Entering PROG or HOLD SHALL drive domains 1..N-1 low at that same edge, i.e. SYNC_STAGES+1 edges after prog_rst_ni falls and 1 edge after ndmreset_i rises.
REQ-022 HOLD SHALL go to RELEASE when ndmreset_i is low and to PROG when synchronised prog is low (prog wins).
REQ-023 A prog or ndmreset request during RELEASE SHALL abort the sequence and take the matching transition.
REQ-024 In RUN, sw_rst_req_i[k]=1 (k>=1) SHALL drive domain k low at the next edge for exactly STRETCH_CYCLES cycles using a per-domain counter; a repeated request mid-stretch SHALL restart the count; bit 0 SHALL be ignored.
REQ-025 Software requests outside RUN SHALL be ignored, and entry to PROG/HOLD SHALL clear all per-domain counters.
REQ-026 Cause bits SHALL set on entry to PROG [1], entry to HOLD [2], and accepted sw request [3]; cause_clr_i SHALL clear all bits, with a simultaneous set taking precedence for its bit.

Reset
REQ-027 While rst_ni is low, the block SHALL asynchronously force domain_rst_no=0, rst_cause_o=4'b0001, busy_o=1, state=RESET, and all counters and synchroniser flops to 0, including mid-RELEASE or mid-stretch.

Verification (NUM_DOMAINS=4, STRETCH_CYCLES=8, SYNC_STAGES=2, BOOT_WAIT_PROG=1)
REQ-028 POR: rst_ni low then high -> domain_rst_no=4'b0000, then 4'b0001 from the first edge onward and held in IDLE; busy_o=1; rst_cause_o=4'b0001.
REQ-029 prog_rst_ni low for 5 cycles then high -> PROG, then RELEASE; domains 1, 2 and 3 rise 8, 16 and 24 edges after RELEASE entry; final 4'b1111, busy_o=0, rst_cause_o=4'b0011.
REQ-030 ndmreset_i high for 3 cycles in RUN -> 4'b0001 one edge later, staggered release after it drops, domain 0 always high, rst_cause_o[2]=1.
REQ-031 sw_rst_req_i=4'b0101 for one cycle in RUN -> domain 2 low for exactly 8 cycles, domains 0, 1 and 3 unaffected, rst_cause_o[3]=1.
REQ-032 prog low coincident with ndmreset_i high -> PROG taken; then rst_ni low mid-RELEASE -> domain_rst_no=4'b0000 immediately without waiting for clk_i.
REQ-033 cause_clr_i in the same cycle as an sw request -> rst_cause_o=4'b1000.
